// File: rtl/core_ldst_dataio_dispatch.sv
// core_ldst_dataio_dispatch
//   Routes one core load/store at a time to the DATA bus or the IO bus.
//   The request goes to the IO bus when ADDR >= IO base, and to the DATA bus otherwise.
//   The IO base is latched from the system-info IOSR broadcast.
//   Each request returns one zero-extended 32-bit result.
// Ports
//   iCLOCK / inRESET          clock, asynchronous active-low reset
//   iSYSINFO_IOSR_VALID/_IOSR IO base update
//   iLDST_* / oLDST_*         core-side request and completion
//   oDATA_* / iDATA_*         DATA bus request (with MMU context) and response
//   oIO_* / iIO_*             IO bus request and response
module core_ldst_dataio_dispatch #(
  parameter bit          P_WAIT_IOSR     = 1'b1,
  parameter logic [31:0] P_IO_BASE_RESET = 32'hFFFF_FFFF
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iSYSINFO_IOSR_VALID,
  input  logic [31:0] iSYSINFO_IOSR,
  input  logic        iLDST_REQ,
  output logic        oLDST_BUSY,
  input  logic [1:0]  iLDST_ORDER,
  input  logic        iLDST_RW,
  input  logic [13:0] iLDST_TID,
  input  logic [1:0]  iLDST_MMUMOD,
  input  logic [31:0] iLDST_PDT,
  input  logic [31:0] iLDST_ADDR,
  input  logic [31:0] iLDST_DATA,
  output logic        oLDST_VALID,
  output logic        oLDST_PAGEFAULT,
  output logic [31:0] oLDST_DATA,
  output logic        oDATA_REQ,
  input  logic        iDATA_LOCK,
  output logic [1:0]  oDATA_ORDER,
  output logic        oDATA_RW,
  output logic [13:0] oDATA_TID,
  output logic [1:0]  oDATA_MMUMOD,
  output logic [31:0] oDATA_PDT,
  output logic [31:0] oDATA_ADDR,
  output logic [31:0] oDATA_DATA,
  input  logic        iDATA_VALID,
  input  logic        iDATA_PAGEFAULT,
  input  logic [63:0] iDATA_DATA,
  output logic        oIO_REQ,
  input  logic        iIO_BUSY,
  output logic [1:0]  oIO_ORDER,
  output logic        oIO_RW,
  output logic [31:0] oIO_ADDR,
  output logic [31:0] oIO_DATA,
  input  logic        iIO_VALID,
  input  logic [31:0] iIO_DATA
);

  typedef enum logic [2:0] {StIdle, StDReq, StDWait, StIReq, StIWait, StDone} stateT;

  stateT       stateQ;
  logic [31:0] baseQ;
  logic        baseValidQ;
  logic [31:0] addrQ;
  logic [1:0]  orderQ;
  logic        rwQ;
  logic [31:0] resultQ;
  logic        faultQ;

  logic        accept;
  logic        routeIo;
  logic [31:0] dataWord;

  // Pick the byte, half or word from a 32-bit bus word. Writes return zero.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] order,
                                          input logic [1:0] lane, input logic rw);
    logic [31:0] r;
    r = '0;
    if (rw) begin
      case (order)
        2'b00:   r = {24'h0, word[{lane, 3'b000} +: 8]};
        2'b01:   r = {16'h0, (lane[1] ? word[31:16] : word[15:0])};
        default: r = word;
      endcase
    end
    return r;
  endfunction

  assign oLDST_BUSY = (stateQ != StIdle) || !baseValidQ;
  assign accept     = iLDST_REQ && !oLDST_BUSY;
  assign routeIo    = (iLDST_ADDR >= baseQ);
  assign dataWord   = addrQ[2] ? iDATA_DATA[63:32] : iDATA_DATA[31:0];

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      stateQ          <= StIdle;
      baseQ           <= P_IO_BASE_RESET;
      baseValidQ      <= !P_WAIT_IOSR;
      addrQ           <= '0;
      orderQ          <= '0;
      rwQ             <= 1'b0;
      resultQ         <= '0;
      faultQ          <= 1'b0;
      oLDST_VALID     <= 1'b0;
      oLDST_PAGEFAULT <= 1'b0;
      oLDST_DATA      <= '0;
      oDATA_REQ       <= 1'b0;
      oDATA_ORDER     <= '0;
      oDATA_RW        <= 1'b0;
      oDATA_TID       <= '0;
      oDATA_MMUMOD    <= '0;
      oDATA_PDT       <= '0;
      oDATA_ADDR      <= '0;
      oDATA_DATA      <= '0;
      oIO_REQ         <= 1'b0;
      oIO_ORDER       <= '0;
      oIO_RW          <= 1'b0;
      oIO_ADDR        <= '0;
      oIO_DATA        <= '0;
    end else begin
      // Base updates apply in any state; an in-flight request keeps its route.
      if (iSYSINFO_IOSR_VALID) begin
        baseQ      <= iSYSINFO_IOSR;
        baseValidQ <= 1'b1;
      end
      oLDST_VALID     <= 1'b0;
      oLDST_PAGEFAULT <= 1'b0;
      case (stateQ)
        StIdle: begin
          if (accept) begin
            addrQ  <= iLDST_ADDR;
            orderQ <= iLDST_ORDER;
            rwQ    <= iLDST_RW;
            if (routeIo) begin
              stateQ    <= StIReq;
              oIO_REQ   <= 1'b1;
              oIO_ORDER <= iLDST_ORDER;
              oIO_RW    <= iLDST_RW;
              oIO_ADDR  <= iLDST_ADDR;
              oIO_DATA  <= iLDST_DATA;
            end else begin
              stateQ       <= StDReq;
              oDATA_REQ    <= 1'b1;
              oDATA_ORDER  <= iLDST_ORDER;
              oDATA_RW     <= iLDST_RW;
              oDATA_TID    <= iLDST_TID;
              oDATA_MMUMOD <= iLDST_MMUMOD;
              oDATA_PDT    <= iLDST_PDT;
              oDATA_ADDR   <= iLDST_ADDR;
              oDATA_DATA   <= iLDST_DATA;
            end
          end
        end
        StDReq: begin
          if (!iDATA_LOCK) begin
            oDATA_REQ <= 1'b0;
            // A response in the same cycle the request is taken also completes.
            if (iDATA_VALID) begin
              resultQ <= extract(dataWord, orderQ, addrQ[1:0], rwQ);
              faultQ  <= iDATA_PAGEFAULT;
              stateQ  <= StDone;
            end else begin
              stateQ <= StDWait;
            end
          end
        end
        StDWait: begin
          if (iDATA_VALID) begin
            resultQ <= extract(dataWord, orderQ, addrQ[1:0], rwQ);
            faultQ  <= iDATA_PAGEFAULT;
            stateQ  <= StDone;
          end
        end
        StIReq: begin
          if (!iIO_BUSY) begin
            oIO_REQ <= 1'b0;
            if (iIO_VALID) begin
              resultQ <= extract(iIO_DATA, orderQ, addrQ[1:0], rwQ);
              faultQ  <= 1'b0;
              stateQ  <= StDone;
            end else begin
              stateQ <= StIWait;
            end
          end
        end
        StIWait: begin
          if (iIO_VALID) begin
            resultQ <= extract(iIO_DATA, orderQ, addrQ[1:0], rwQ);
            faultQ  <= 1'b0;
            stateQ  <= StDone;
          end
        end
        StDone: begin
          oLDST_VALID     <= 1'b1;
          oLDST_PAGEFAULT <= faultQ;
          oLDST_DATA      <= resultQ;
          stateQ          <= StIdle;
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ldst_dataio_dispatch.sv
module tb_core_ldst_dataio_dispatch;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iSYSINFO_IOSR_VALID;
  logic [31:0] iSYSINFO_IOSR;
  logic        iLDST_REQ;
  logic        oLDST_BUSY;
  logic [1:0]  iLDST_ORDER;
  logic        iLDST_RW;
  logic [13:0] iLDST_TID;
  logic [1:0]  iLDST_MMUMOD;
  logic [31:0] iLDST_PDT;
  logic [31:0] iLDST_ADDR;
  logic [31:0] iLDST_DATA;
  logic        oLDST_VALID;
  logic        oLDST_PAGEFAULT;
  logic [31:0] oLDST_DATA;
  logic        oDATA_REQ;
  logic        iDATA_LOCK;
  logic [1:0]  oDATA_ORDER;
  logic        oDATA_RW;
  logic [13:0] oDATA_TID;
  logic [1:0]  oDATA_MMUMOD;
  logic [31:0] oDATA_PDT;
  logic [31:0] oDATA_ADDR;
  logic [31:0] oDATA_DATA;
  logic        iDATA_VALID;
  logic        iDATA_PAGEFAULT;
  logic [63:0] iDATA_DATA;
  logic        oIO_REQ;
  logic        iIO_BUSY;
  logic [1:0]  oIO_ORDER;
  logic        oIO_RW;
  logic [31:0] oIO_ADDR;
  logic [31:0] oIO_DATA;
  logic        iIO_VALID;
  logic [31:0] iIO_DATA;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        pf;
  } expT;
  expT sb[$];
  expT monE;

  core_ldst_dataio_dispatch dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iSYSINFO_IOSR_VALID(iSYSINFO_IOSR_VALID), .iSYSINFO_IOSR(iSYSINFO_IOSR),
    .iLDST_REQ(iLDST_REQ), .oLDST_BUSY(oLDST_BUSY), .iLDST_ORDER(iLDST_ORDER),
    .iLDST_RW(iLDST_RW), .iLDST_TID(iLDST_TID), .iLDST_MMUMOD(iLDST_MMUMOD),
    .iLDST_PDT(iLDST_PDT), .iLDST_ADDR(iLDST_ADDR), .iLDST_DATA(iLDST_DATA),
    .oLDST_VALID(oLDST_VALID), .oLDST_PAGEFAULT(oLDST_PAGEFAULT), .oLDST_DATA(oLDST_DATA),
    .oDATA_REQ(oDATA_REQ), .iDATA_LOCK(iDATA_LOCK), .oDATA_ORDER(oDATA_ORDER),
    .oDATA_RW(oDATA_RW), .oDATA_TID(oDATA_TID), .oDATA_MMUMOD(oDATA_MMUMOD),
    .oDATA_PDT(oDATA_PDT), .oDATA_ADDR(oDATA_ADDR), .oDATA_DATA(oDATA_DATA),
    .iDATA_VALID(iDATA_VALID), .iDATA_PAGEFAULT(iDATA_PAGEFAULT), .iDATA_DATA(iDATA_DATA),
    .oIO_REQ(oIO_REQ), .iIO_BUSY(iIO_BUSY), .oIO_ORDER(oIO_ORDER), .oIO_RW(oIO_RW),
    .oIO_ADDR(oIO_ADDR), .oIO_DATA(oIO_DATA), .iIO_VALID(iIO_VALID), .iIO_DATA(iIO_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] order, input logic rw, input logic [31:0] addr,
                       input logic [31:0] wdata);
    iLDST_REQ   = 1'b1;
    iLDST_ORDER = order;
    iLDST_RW    = rw;
    iLDST_ADDR  = addr;
    iLDST_DATA  = wdata;
    iLDST_TID   = 14'h1234;
    iLDST_MMUMOD = 2'b01;
    iLDST_PDT   = 32'h0000_4000;
  endtask

  // Entered at a negedge; returns at the negedge where oLDST_VALID is seen (or the bound expires).
  task automatic waitValid(input int maxCyc, input string tag);
    int n = 0;
    while (!oLDST_VALID && n < maxCyc) begin
      @(negedge iCLOCK);
      n++;
    end
    check(tag, {31'h0, oLDST_VALID}, 32'h1);
  endtask

  // Scoreboard: every completion pops the oldest expected result.
  always @(negedge iCLOCK) begin
    if (inRESET && oLDST_VALID) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'h0, oLDST_VALID}, 32'h0);
      end else begin
        monE = sb.pop_front();
        check("sb_rdata", oLDST_DATA, monE.data);
        check("sb_pagefault", {31'h0, oLDST_PAGEFAULT}, {31'h0, monE.pf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    inRESET = 1'b0;
    iSYSINFO_IOSR_VALID = 1'b0; iSYSINFO_IOSR = '0;
    iLDST_REQ = 1'b0; iLDST_ORDER = '0; iLDST_RW = 1'b0; iLDST_TID = '0;
    iLDST_MMUMOD = '0; iLDST_PDT = '0; iLDST_ADDR = '0; iLDST_DATA = '0;
    iDATA_LOCK = 1'b0; iDATA_VALID = 1'b0; iDATA_PAGEFAULT = 1'b0; iDATA_DATA = '0;
    iIO_BUSY = 1'b0; iIO_VALID = 1'b0; iIO_DATA = '0;
    repeat (3) @(negedge iCLOCK);
    inRESET = 1'b1;
    @(negedge iCLOCK);
    check("rst_busy", {31'h0, oLDST_BUSY}, 32'h1);
    check("rst_dreq", {31'h0, oDATA_REQ}, 32'h0);
    check("rst_ioreq", {31'h0, oIO_REQ}, 32'h0);
    check("rst_valid", {31'h0, oLDST_VALID}, 32'h0);
    check("rst_ldata", oLDST_DATA, 32'h0);

    // Request held with no IO base yet: nothing may go out.
    issue(2'b10, 1'b1, 32'h0000_1004, 32'h0);
    sb.push_back('{data: 32'h1122_3344, pf: 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge iCLOCK);
      check("noiosr_busy", {31'h0, oLDST_BUSY}, 32'h1);
      check("noiosr_req", {30'h0, oDATA_REQ, oIO_REQ}, 32'h0);
    end
    iSYSINFO_IOSR_VALID = 1'b1; iSYSINFO_IOSR = 32'h8000_0000;
    @(negedge iCLOCK);
    iSYSINFO_IOSR_VALID = 1'b0;
    check("iosr_busy_drop", {31'h0, oLDST_BUSY}, 32'h0);
    @(negedge iCLOCK);                  // accepted on the edge before this
    iLDST_REQ = 1'b0;
    check("w_dreq", {31'h0, oDATA_REQ}, 32'h1);
    check("w_ioreq", {31'h0, oIO_REQ}, 32'h0);
    check("w_daddr", oDATA_ADDR, 32'h0000_1004);
    check("w_drw", {31'h0, oDATA_RW}, 32'h1);
    check("w_dtid", {18'h0, oDATA_TID}, 32'h1234);
    @(negedge iCLOCK);
    check("w_dreq_1cyc", {31'h0, oDATA_REQ}, 32'h0);
    iDATA_VALID = 1'b1; iDATA_DATA = 64'h1122_3344_5566_7788;
    @(negedge iCLOCK);
    iDATA_VALID = 1'b0;
    check("w_not_early", {31'h0, oLDST_VALID}, 32'h0);
    @(negedge iCLOCK);
    check("w_lat3_valid", {31'h0, oLDST_VALID}, 32'h1);
    check("w_busy_drop", {31'h0, oLDST_BUSY}, 32'h0);

    // IO byte read with two stall cycles.
    issue(2'b00, 1'b1, 32'h8000_0003, 32'h0);
    iIO_BUSY = 1'b1;
    sb.push_back('{data: 32'h0000_00AA, pf: 1'b0});
    @(negedge iCLOCK);
    iLDST_REQ = 1'b0;
    check("io_dreq", {31'h0, oDATA_REQ}, 32'h0);
    check("io_addr", oIO_ADDR, 32'h8000_0003);
    check("io_order", {30'h0, oIO_ORDER}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) iIO_BUSY = 1'b0;
      check("io_req_held", {31'h0, oIO_REQ}, 32'h1);
      if (i < 2) @(negedge iCLOCK);
    end
    @(negedge iCLOCK);
    check("io_req_drop", {31'h0, oIO_REQ}, 32'h0);
    iIO_VALID = 1'b1; iIO_DATA = 32'hAABB_CCDD;
    @(negedge iCLOCK);
    iIO_VALID = 1'b0;
    waitValid(5, "io_byte_done");

    // DATA word write with a lock cycle and a page fault.
    issue(2'b10, 1'b0, 32'h7FFF_FFFC, 32'hDEAD_BEEF);
    iDATA_LOCK = 1'b1;
    sb.push_back('{data: 32'h0, pf: 1'b1});
    @(negedge iCLOCK);
    iLDST_REQ = 1'b0;
    check("wr_dreq", {31'h0, oDATA_REQ}, 32'h1);
    check("wr_rw", {31'h0, oDATA_RW}, 32'h0);
    check("wr_wdata", oDATA_DATA, 32'hDEAD_BEEF);
    @(negedge iCLOCK);
    check("wr_lock_hold", {31'h0, oDATA_REQ}, 32'h1);
    iDATA_LOCK = 1'b0;
    @(negedge iCLOCK);
    check("wr_dreq_drop", {31'h0, oDATA_REQ}, 32'h0);
    iDATA_VALID = 1'b1; iDATA_PAGEFAULT = 1'b1; iDATA_DATA = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge iCLOCK);
    iDATA_VALID = 1'b0; iDATA_PAGEFAULT = 1'b0;
    waitValid(5, "wr_done");
    check("wr_pf", {31'h0, oLDST_PAGEFAULT}, 32'h1);

    // Base moves while an IO read is outstanding.
    issue(2'b10, 1'b1, 32'h9000_0000, 32'h0);
    sb.push_back('{data: 32'h1234_5678, pf: 1'b0});
    @(negedge iCLOCK);
    iLDST_REQ = 1'b0;
    iSYSINFO_IOSR_VALID = 1'b1; iSYSINFO_IOSR = 32'h0000_1000;
    check("mv_ioreq", {31'h0, oIO_REQ}, 32'h1);
    @(negedge iCLOCK);
    iSYSINFO_IOSR_VALID = 1'b0;
    check("mv_no_dreq", {30'h0, oDATA_REQ, oIO_REQ}, 32'h0);
    iIO_VALID = 1'b1; iIO_DATA = 32'h1234_5678;
    @(negedge iCLOCK);
    iIO_VALID = 1'b0;
    waitValid(5, "mv_done");
    issue(2'b01, 1'b1, 32'h0000_2002, 32'h0);
    sb.push_back('{data: 32'h0000_CAFE, pf: 1'b0});
    @(negedge iCLOCK);
    iLDST_REQ = 1'b0;
    check("nb_ioreq", {31'h0, oIO_REQ}, 32'h1);
    check("nb_dreq", {31'h0, oDATA_REQ}, 32'h0);
    iIO_VALID = 1'b1; iIO_DATA = 32'hCAFE_F00D;   // same cycle as the request is taken
    @(negedge iCLOCK);
    iIO_VALID = 1'b0;
    waitValid(5, "nb_done");

    // Stray responses while idle are ignored.
    iDATA_VALID = 1'b1; iIO_VALID = 1'b1;
    @(negedge iCLOCK);
    iDATA_VALID = 1'b0; iIO_VALID = 1'b0;
    @(negedge iCLOCK);
    check("stray_ignored", {31'h0, oLDST_VALID}, 32'h0);

    // DATA byte read (upper word, lane 1) with the response in the request cycle.
    issue(2'b00, 1'b1, 32'h0000_0005, 32'h0);
    sb.push_back('{data: 32'h0000_0033, pf: 1'b0});
    @(negedge iCLOCK);
    iLDST_REQ = 1'b0;
    check("sc_dreq", {31'h0, oDATA_REQ}, 32'h1);
    iDATA_VALID = 1'b1; iDATA_DATA = 64'h1122_3344_5566_7788;
    @(negedge iCLOCK);
    iDATA_VALID = 1'b0;
    check("sc_not_early", {31'h0, oLDST_VALID}, 32'h0);
    @(negedge iCLOCK);
    check("sc_valid", {31'h0, oLDST_VALID}, 32'h1);

    // Reset during D_WAIT: transaction abandoned, late response ignored.
    issue(2'b10, 1'b1, 32'h0000_0100, 32'h0);
    @(negedge iCLOCK);
    iLDST_REQ = 1'b0;
    check("rs_dreq", {31'h0, oDATA_REQ}, 32'h1);
    @(negedge iCLOCK);
    inRESET = 1'b0;
    #1;
    check("rs_async_daddr", oDATA_ADDR, 32'h0);
    check("rs_async_ldata", oLDST_DATA, 32'h0);
    check("rs_async_busy", {31'h0, oLDST_BUSY}, 32'h1);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    iDATA_VALID = 1'b1; iDATA_DATA = 64'h5555_5555_5555_5555;
    @(negedge iCLOCK);
    iDATA_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rs_no_valid", {31'h0, oLDST_VALID}, 32'h0);
      @(negedge iCLOCK);
    end
    check("rs_busy", {31'h0, oLDST_BUSY}, 32'h1);
    check("rs_reqs", {30'h0, oDATA_REQ, oIO_REQ}, 32'h0);
    check("sb_empty", sb.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
